// File: rtl/alu_mext_pkg.sv
// alu_pkg: alu_sel encodings, FSM states and the iterative-op classifier (honours ALU_FAST_MUL_EN)
package alu_pkg;
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_SLL = 5'd2;
  localparam logic [4:0] ALU_SLT = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR = 5'd5;
  localparam logic [4:0] ALU_SRL = 5'd6;
  localparam logic [4:0] ALU_SRA = 5'd7;
  localparam logic [4:0] ALU_OR = 5'd8;
  localparam logic [4:0] ALU_AND = 5'd9;
  localparam logic [4:0] ALU_B_OUT = 5'd11;
  localparam logic [4:0] ALU_MUL = 5'd16;
  localparam logic [4:0] ALU_MULH = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU = 5'd19;
  localparam logic [4:0] ALU_DIV = 5'd20;
  localparam logic [4:0] ALU_DIVU = 5'd21;
  localparam logic [4:0] ALU_REM = 5'd22;
  localparam logic [4:0] ALU_REMU = 5'd23;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  function automatic logic is_iterative(input logic [4:0] op);
`ifdef ALU_FAST_MUL_EN
    return op[4:2] == 3'b101;
`else
    return op[4:3] == 2'b10;
`endif
  endfunction
endpackage

// File: rtl/alu_mext_if.sv
// alu_mext_if: request/response handshake bundle between the execute stage and alu_mext
interface alu_mext_if #(parameter int XLEN = 32);
  logic in_valid;
  logic in_ready;
  logic [4:0] alu_sel;
  logic [XLEN-1:0] data_a;
  logic [XLEN-1:0] data_b;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] alu_out;
  modport master (output in_valid, alu_sel, data_a, data_b, out_ready, input in_ready, out_valid, alu_out);
  modport slave (input in_valid, alu_sel, data_a, data_b, out_ready, output in_ready, out_valid, alu_out);
endinterface

// File: rtl/alu_mext_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle shift-add multiplier and restoring divider on magnitudes, sign fixed on the last step
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            busy,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  logic [4:0] op_q;
  logic neg_q, rneg_q, sa, sb, mul_op, start_mul;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] d_q, hi_q, lo_q, ma, mb, hi_n, lo_n, quo, rem;
  logic [XLEN:0] sum, r_sh, diff;
  logic [2*XLEN-1:0] prod;
  assign sa = a[XLEN-1] && (op == ALU_MULH || op == ALU_MULHSU || op == ALU_DIV || op == ALU_REM);
  assign sb = b[XLEN-1] && (op == ALU_MULH || op == ALU_DIV || op == ALU_REM);
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;
  assign start_mul = op[4:2] == 3'b100;
  assign mul_op = op_q[4:2] == 3'b100;
  assign sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : '0);
  assign r_sh = {hi_q, lo_q[XLEN-1]};
  assign diff = r_sh - {1'b0, d_q};
  assign hi_n = mul_op ? sum[XLEN:1] : (diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0]);
  assign lo_n = mul_op ? {sum[0], lo_q[XLEN-1:1]} : {lo_q[XLEN-2:0], !diff[XLEN]};
  assign prod = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
  assign quo = neg_q ? -lo_n : lo_n;
  assign rem = rneg_q ? -hi_n : hi_n;
  assign result = mul_op ? (op_q == ALU_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) : (op_q[1] ? rem : quo);
  assign last = cnt == CW'(XLEN - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      cnt <= '0;
      d_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else if (start) begin
      op_q <= op;
      neg_q <= sa ^ sb;
      rneg_q <= sa;
      cnt <= '0;
      d_q <= start_mul ? ma : mb;
      hi_q <= '0;
      lo_q <= start_mul ? mb : ma;
    end else if (busy) begin
      hi_q <= hi_n;
      lo_q <= lo_n;
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/alu_mext.sv
// alu_mext: handshaked RV32/64 ALU with M extension; ALU_FAST_MUL_EN selects a single-cycle multiplier
module alu_mext
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input logic clk,
  input logic rst,
  alu_mext_if.slave bus
);
  state_e state, state_n;
  logic [XLEN-1:0] a, b, base, iter_res, out_q;
  logic [SHAMT_W-1:0] sh;
  logic [4:0] op;
  logic accept, iter, early, last, is_div, ovf;
  assign a = bus.data_a;
  assign b = bus.data_b;
  assign op = bus.alu_sel;
  assign sh = b[SHAMT_W-1:0];
  assign is_div = op[4:2] == 3'b101;
  assign ovf = !op[0] && a == {1'b1, {(XLEN-1){1'b0}}} && &b;
  assign early = is_div && (b == '0 || ovf);
  assign iter = is_iterative(op) && !early;
  assign bus.in_ready = state == IDLE || (state == DONE && bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign bus.out_valid = state == DONE;
  assign bus.alu_out = out_q;
`ifdef ALU_FAST_MUL_EN
  logic [2*XLEN-1:0] prod;
  assign prod = {{XLEN{a[XLEN-1] & (op == ALU_MULH || op == ALU_MULHSU)}}, a} * {{XLEN{b[XLEN-1] & (op == ALU_MULH)}}, b};
`endif
  always_comb begin
    base = '0;
    case (op)
      ALU_ADD: base = a + b;
      ALU_SUB: base = a - b;
      ALU_SLL: base = a << sh;
      ALU_SLT: base = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: base = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR: base = a ^ b;
      ALU_SRL: base = a >> sh;
      ALU_SRA: base = $signed(a) >>> sh;
      ALU_OR: base = a | b;
      ALU_AND: base = a & b;
      ALU_B_OUT: base = b;
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: base = b == '0 ? (op[1] ? a : '1) : (op[1] ? '0 : a);
`ifdef ALU_FAST_MUL_EN
      ALU_MUL: base = prod[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: base = prod[2*XLEN-1:XLEN];
`endif
      default: base = '0;
    endcase
  end
  always_comb begin
    state_n = accept ? (iter ? BUSY : DONE) : state == BUSY ? (last ? DONE : BUSY) : (state == DONE && bus.out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_q <= '0;
    end else begin
      state <= state_n;
      if (accept && !iter) out_q <= base;
      else if (state == BUSY && last) out_q <= iter_res;
    end
  end
  alu_muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk(clk),
    .rst(rst),
    .start(accept && iter),
    .busy(state == BUSY),
    .op(op),
    .a(a),
    .b(b),
    .last(last),
    .result(iter_res)
  );
endmodule

// File: tb/tb_alu_mext.sv
// tb_alu_mext: scoreboard bench for alu_mext checking results, latency, backpressure and mid-operation reset
module tb_alu_mext;
  typedef struct {
    string tag;
    logic [31:0] val;
    int lat;
    int acc;
  } exp_t;
  logic clk, rst;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  exp_t exp_q[$];
  alu_mext_if #(.XLEN(32)) bus ();
  alu_mext #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic int lat_of(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 5'd20 && op <= 5'd23) begin
      if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
      return 33;
    end
`ifdef ALU_FAST_MUL_EN
    return 1;
`else
    if (op >= 5'd16 && op <= 5'd19) return 33;
    return 1;
`endif
  endfunction
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, r;
    longint p;
    logic [63:0] u;
    sa = a;
    sb = b;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a << b[4:0];
      3: return (sa < sb) ? 32'd1 : 32'd0;
      4: return (a < b) ? 32'd1 : 32'd0;
      5: return a ^ b;
      6: return a >> b[4:0];
      7: begin
        r = sa >>> b[4:0];
        return r;
      end
      8: return a | b;
      9: return a & b;
      11: return b;
      16: return a * b;
      17: begin
        p = longint'(sa) * longint'(sb);
        return p[63:32];
      end
      18: begin
        p = longint'(sa) * longint'({32'b0, b});
        return p[63:32];
      end
      19: begin
        u = {32'b0, a} * {32'b0, b};
        return u[63:32];
      end
      20: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        r = sa / sb;
        return r;
      end
      21: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      22: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        r = sa % sb;
        return r;
      end
      23: begin
        if (b == 0) return a;
        return a % b;
      end
      default: return 0;
    endcase
  endfunction
  task automatic issue(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input int lat = 0);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.alu_sel = op;
    bus.data_a = a;
    bus.data_b = b;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready) exp_q.push_back('{tag, exp, (lat == 0) ? lat_of(op, a, b) : lat, cyc});
    else check({tag, "_accept"}, 64'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 64'(exp_q.size()), 0);
  endtask
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("spurious_out_valid", 64'(bus.out_valid), 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.tag, 64'(bus.alu_out), 64'(e.val));
        check({e.tag, "_lat"}, 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [4:0] ops [22] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 11, 16, 17, 18, 19, 20, 21, 22, 23, 10, 24, 31};
    logic [31:0] ra, rb;
    logic [4:0] rop;
    int c0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.alu_sel = '0;
    bus.data_a = '0;
    bus.data_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 64'(bus.out_valid), 0);
    check("rst_alu_out", 64'(bus.alu_out), 0);
    check("rst_in_ready", 64'(bus.in_ready), 1);
    issue("add_basic", 5'd0, 32'd5, 32'hFFFF_FFFD, 32'd2);
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      issue("add_b2b", 5'd0, ra, rb, ra + rb);
    end
    check("b2b_cycles", 64'(cyc - c0), 10);
    issue("sra", 5'd7, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000);
    issue("sltu", 5'd4, 32'd1, 32'hFFFF_FFFF, 32'd1);
    issue("slt", 5'd3, 32'd1, 32'hFFFF_FFFF, 32'd0);
    issue("div_by0", 5'd20, 32'd7, 32'd0, 32'hFFFF_FFFF);
    issue("rem_by0", 5'd22, 32'd7, 32'd0, 32'd7);
    issue("divu_by0", 5'd21, 32'd9, 32'd0, 32'hFFFF_FFFF);
    issue("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    issue("rem_ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    issue("mulhu", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue("mulh", 5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    issue("mul", 5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    issue("mulhsu", 5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue("div_neg", 5'd20, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    issue("rem_neg", 5'd22, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    issue("divu", 5'd21, 32'd100, 32'd7, 32'd14);
    issue("remu", 5'd23, 32'd100, 32'd7, 32'd2);
    for (int i = 0; i < 24; i++) begin
      rop = ops[$urandom_range(0, 21)];
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      issue($sformatf("rnd_op%0d", rop), rop, ra, rb, model(rop, ra, rb));
    end
    drain();
    bus.out_ready = 1'b0;
    issue("bp_add", 5'd0, 32'd100, 32'd23, 32'd123, 6);
    bus.in_valid = 1'b1;
    bus.alu_sel = 5'd5;
    bus.data_a = 32'h0000_F0F0;
    bus.data_b = 32'h0000_0FF0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_out", 64'(bus.alu_out), 123);
      check("bp_hold_valid", 64'(bus.out_valid), 1);
      check("bp_in_ready", 64'(bus.in_ready), 0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    issue("bp_xor", 5'd5, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00);
    drain();
    issue("rst_divu", 5'd21, 32'd1000, 32'd7, 32'd142);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    check("rst_mid_out_valid", 64'(bus.out_valid), 0);
    check("rst_mid_alu_out", 64'(bus.alu_out), 0);
    check("rst_mid_in_ready", 64'(bus.in_ready), 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("rst_no_stale", 64'(bus.out_valid), 0);
    end
    @(posedge clk);
    #1;
    issue("post_rst_divu", 5'd21, 32'd1000, 32'd7, 32'd142);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
